// File: rtl/sprite_line_scanner.sv
// Sprite line scanner: walks the sprite attribute RAM for one video line and
// streams the intersecting sprites to the line renderer, bounded by a per-line budget.
module sprite_line_scanner #(
  parameter int NUM_SPRITES  = 128,
  parameter int MAX_PER_LINE = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_idx_i,
  output logic        ram_rd_en_o,
  output logic [7:0]  ram_rd_addr_o,
  input  logic [31:0] ram_rd_data_i,
  output logic        spr_valid_o,
  input  logic        spr_ready_i,
  output logic [6:0]  spr_idx_o,
  output logic [11:0] spr_addr_o,
  output logic        spr_mode_o,
  output logic [9:0]  spr_x_o,
  output logic [5:0]  spr_row_o,
  output logic        spr_hflip_o,
  output logic [1:0]  spr_z_o,
  output logic [3:0]  spr_coll_o,
  output logic [3:0]  spr_pal_o,
  output logic [1:0]  spr_width_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overflow_o
);

  // state   | meaning
  // IDLE    | waiting for line_start_i
  // RD_EVEN | read request for word0 of sprite idx
  // RD_ODD  | read request for word1, word0 arrives and is captured
  // EVAL    | word1 on the read bus, hit test
  // EMIT    | record offered to the renderer
  // DONE    | scan finished; done_o pulses in the following cycle
  typedef enum logic [2:0] {IDLE, RD_EVEN, RD_ODD, EVAL, EMIT, DONE} state_t;

  state_t      state_q;
  logic [9:0]  line_q;
  logic [6:0]  idx_q;
  logic [7:0]  hit_cnt_q;
  logic [31:0] word0_q;

  logic [9:0]  row;
  logic [6:0]  height;
  logic [5:0]  row_out;
  logic        hit;
  logic        last_idx;
  logic [7:0]  hit_cnt_nxt;
  logic        budget_full;
  logic        advance;
  logic        unused_bits;

  assign unused_bits = ^{word0_q[31:26], word0_q[14:12], ram_rd_data_i[15:10]};

  // Hit test on word1 as it sits on the read bus during EVAL; row wraps mod 1024.
  always_comb begin
    row         = line_q - ram_rd_data_i[9:0];
    height      = 7'd8 << ram_rd_data_i[31:30];
    hit         = (ram_rd_data_i[19:18] != 2'b00) && (row < {3'b000, height});
    row_out     = ram_rd_data_i[17] ? (6'(height - 7'd1) - row[5:0]) : row[5:0];
    last_idx    = (idx_q == 7'(NUM_SPRITES - 1));
    hit_cnt_nxt = hit_cnt_q + {7'd0, (state_q == EMIT)};
    budget_full = (hit_cnt_nxt == 8'(MAX_PER_LINE));
    advance     = ((state_q == EVAL) && !hit) || ((state_q == EMIT) && spr_ready_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      line_q        <= '0;
      idx_q         <= '0;
      hit_cnt_q     <= '0;
      word0_q       <= '0;
      ram_rd_en_o   <= 1'b0;
      ram_rd_addr_o <= '0;
      spr_valid_o   <= 1'b0;
      spr_idx_o     <= '0;
      spr_addr_o    <= '0;
      spr_mode_o    <= 1'b0;
      spr_x_o       <= '0;
      spr_row_o     <= '0;
      spr_hflip_o   <= 1'b0;
      spr_z_o       <= '0;
      spr_coll_o    <= '0;
      spr_pal_o     <= '0;
      spr_width_o   <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      overflow_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (line_start_i) begin
        // Start or restart from any state; a coincident handshake is discarded.
        line_q        <= line_idx_i;
        idx_q         <= '0;
        hit_cnt_q     <= '0;
        overflow_o    <= 1'b0;
        spr_valid_o   <= 1'b0;
        busy_o        <= 1'b1;
        ram_rd_en_o   <= 1'b1;
        ram_rd_addr_o <= '0;
        state_q       <= RD_EVEN;
      end else begin
        case (state_q)
          IDLE: ;
          RD_EVEN: begin
            ram_rd_addr_o <= {idx_q, 1'b1};
            state_q       <= RD_ODD;
          end
          RD_ODD: begin
            word0_q     <= ram_rd_data_i;
            ram_rd_en_o <= 1'b0;
            state_q     <= EVAL;
          end
          EVAL: begin
            if (hit) begin
              spr_valid_o <= 1'b1;
              spr_idx_o   <= idx_q;
              spr_addr_o  <= word0_q[11:0];
              spr_mode_o  <= word0_q[15];
              spr_x_o     <= word0_q[25:16];
              spr_row_o   <= row_out;
              spr_hflip_o <= ram_rd_data_i[16];
              spr_z_o     <= ram_rd_data_i[19:18];
              spr_coll_o  <= ram_rd_data_i[23:20];
              spr_pal_o   <= ram_rd_data_i[27:24];
              spr_width_o <= ram_rd_data_i[29:28];
              state_q     <= EMIT;
            end
          end
          EMIT: begin
            if (spr_ready_i) begin
              spr_valid_o <= 1'b0;
              hit_cnt_q   <= hit_cnt_nxt;
            end
          end
          DONE: begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase

        if (advance) begin
          if (budget_full && !last_idx) begin
            overflow_o <= 1'b1;
            state_q    <= DONE;
          end else if (last_idx) begin
            state_q <= DONE;
          end else begin
            idx_q         <= idx_q + 7'd1;
            ram_rd_en_o   <= 1'b1;
            ram_rd_addr_o <= {idx_q + 7'd1, 1'b0};
            state_q       <= RD_EVEN;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_line_scanner.sv
// Bench for sprite_line_scanner: a full-size instance and a small budget-limited
// instance share one attribute RAM image; emitted records are checked against a list model.
module tb_sprite_line_scanner;

  typedef logic [48:0] rec_t;
  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          line;
    int          exp_hit;
    int          exp_row;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [9:0]  line_idx;
  logic        spr_ready;
  logic [31:0] mem [256];

  logic        en_a, valid_a, mode_a, hflip_a, busy_a, done_a, ovf_a;
  logic [7:0]  raddr_a;
  logic [31:0] rdata_a;
  logic [6:0]  idx_a;
  logic [11:0] addr_a;
  logic [9:0]  x_a;
  logic [5:0]  row_a;
  logic [1:0]  z_a, width_a;
  logic [3:0]  coll_a, pal_a;

  logic        en_b, valid_b, mode_b, hflip_b, busy_b, done_b, ovf_b;
  logic [7:0]  raddr_b;
  logic [31:0] rdata_b;
  logic [6:0]  idx_b;
  logic [11:0] addr_b;
  logic [9:0]  x_b;
  logic [5:0]  row_b;
  logic [1:0]  z_b, width_b;
  logic [3:0]  coll_b, pal_b;

  rec_t pack_a, pack_b;
  assign pack_a = {idx_a, addr_a, mode_a, x_a, row_a, hflip_a, z_a, coll_a, pal_a, width_a};
  assign pack_b = {idx_b, addr_b, mode_b, x_b, row_b, hflip_b, z_b, coll_b, pal_b, width_b};

  sprite_line_scanner dut (
    .clk_i(clk), .rst_i(rst), .line_start_i(line_start), .line_idx_i(line_idx),
    .ram_rd_en_o(en_a), .ram_rd_addr_o(raddr_a), .ram_rd_data_i(rdata_a),
    .spr_valid_o(valid_a), .spr_ready_i(spr_ready), .spr_idx_o(idx_a),
    .spr_addr_o(addr_a), .spr_mode_o(mode_a), .spr_x_o(x_a), .spr_row_o(row_a),
    .spr_hflip_o(hflip_a), .spr_z_o(z_a), .spr_coll_o(coll_a), .spr_pal_o(pal_a),
    .spr_width_o(width_a), .busy_o(busy_a), .done_o(done_a), .overflow_o(ovf_a)
  );

  sprite_line_scanner #(.NUM_SPRITES(8), .MAX_PER_LINE(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .line_start_i(line_start), .line_idx_i(line_idx),
    .ram_rd_en_o(en_b), .ram_rd_addr_o(raddr_b), .ram_rd_data_i(rdata_b),
    .spr_valid_o(valid_b), .spr_ready_i(spr_ready), .spr_idx_o(idx_b),
    .spr_addr_o(addr_b), .spr_mode_o(mode_b), .spr_x_o(x_b), .spr_row_o(row_b),
    .spr_hflip_o(hflip_b), .spr_z_o(z_b), .spr_coll_o(coll_b), .spr_pal_o(pal_b),
    .spr_width_o(width_b), .busy_o(busy_b), .done_o(done_b), .overflow_o(ovf_b)
  );

  always #5 clk = ~clk;

  // 1-cycle registered read ports of the attribute RAM
  always @(posedge clk) begin
    if (en_a) rdata_a <= mem[raddr_a];
    if (en_b) rdata_b <= mem[raddr_b];
  end

  int   tests = 0;
  int   failed = 0;
  int   cyc, first_en, done_cyc;
  int   done_cnt_a, done_cnt_b;
  bit   ovf_done_a, ovf_done_b, ovf_b_post_start;
  bit   ready_mode, ready_fixed;
  rec_t got_a[$], got_b[$], exp_q[$];
  bit   exp_ovf;
  vec_t tab[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_w1(input int y, input int code, input int z,
                                        input bit vf, input bit hf);
    logic [31:0] w;
    w = '0;
    w[9:0]   = 10'(y);
    w[31:30] = 2'(code);
    w[19:18] = 2'(z);
    w[17]    = vf;
    w[16]    = hf;
    w[23:20] = 4'h9;
    w[27:24] = 4'h6;
    w[29:28] = 2'd3;
    return w;
  endfunction

  // Reference: list of records the scan must produce, straight from the sprite rules.
  task automatic model(input int line, input int nspr, input int maxl);
    logic [31:0] w0, w1;
    int r, h, ro;
    exp_q.delete();
    exp_ovf = 0;
    for (int n = 0; n < nspr; n++) begin
      w0 = mem[2*n];
      w1 = mem[2*n+1];
      r  = line - int'(w1[9:0]);
      if (r < 0) r += 1024;
      h  = 8 << int'(w1[31:30]);
      if (w1[19:18] != 2'b00 && r < h) begin
        ro = w1[17] ? (h - 1 - r) : r;
        exp_q.push_back({7'(n), w0[11:0], w0[15], w0[25:16], 6'(ro), w1[16],
                         w1[19:18], w1[23:20], w1[27:24], w1[29:28]});
        if (exp_q.size() == maxl) begin
          if (n < nspr - 1) exp_ovf = 1;
          break;
        end
      end
    end
  endtask

  task automatic step(input bit ls);
    @(negedge clk);
    line_start = ls;
    if (ready_mode) spr_ready = ($urandom_range(0, 1) == 1);
    else spr_ready = ready_fixed;
    cyc++;
    if (!ls && valid_a && spr_ready) got_a.push_back(pack_a);
    if (!ls && valid_b && spr_ready) got_b.push_back(pack_b);
    if (done_a) begin
      done_cnt_a++;
      ovf_done_a = ovf_a;
      if (done_cyc < 0) done_cyc = cyc;
    end
    if (done_b) begin
      done_cnt_b++;
      ovf_done_b = ovf_b;
    end
    if (en_a && first_en < 0) first_en = cyc;
  endtask

  task automatic clear_obs();
    got_a.delete();
    got_b.delete();
    done_cnt_a = 0;
    done_cnt_b = 0;
    ovf_done_a = 0;
    ovf_done_b = 0;
    first_en   = -1;
    done_cyc   = -1;
    cyc        = 0;
  endtask

  task automatic run_scan(input int line, input int budget);
    int n;
    clear_obs();
    line_idx = 10'(line);
    step(1);
    step(0);
    ovf_b_post_start = ovf_b;
    n = 0;
    while (!(done_cnt_a > 0 && done_cnt_b > 0) && n < budget) begin
      step(0);
      n++;
    end
    if (n >= budget) begin
      tests++;
      failed++;
      $display("FAIL scan_timeout: line %0d, done counts %0d/%0d, required both 1",
               line, done_cnt_a, done_cnt_b);
    end
  endtask

  task automatic compare_scan(input string tag, input bit which, input int nspr,
                              input int maxl, input int line);
    rec_t g[$];
    int   dc;
    bit   ov;
    model(line, nspr, maxl);
    if (which) begin g = got_b; dc = done_cnt_b; ov = ovf_done_b; end
    else begin g = got_a; dc = done_cnt_a; ov = ovf_done_a; end
    check({tag, "_count"}, 64'(g.size()), 64'(exp_q.size()));
    for (int i = 0; i < g.size() && i < exp_q.size(); i++)
      check({tag, "_rec"}, 64'(g[i]), 64'(exp_q[i]));
    check({tag, "_done"}, 64'(dc), 64'd1);
    check({tag, "_ovf"}, 64'(ov), 64'(exp_ovf));
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t hold;
    int   stable_err, rd_err, n, line;

    tab[0]  = '{32'h003C_8100, mk_w1(3, 1, 1, 0, 0),    10,   1, 7};
    tab[1]  = '{32'h003C_8100, mk_w1(3, 1, 1, 1, 0),    10,   1, 8};
    tab[2]  = '{32'h003C_8100, mk_w1(3, 1, 1, 0, 0),    19,   0, 0};
    tab[3]  = '{32'h003C_8100, mk_w1(3, 1, 2, 1, 1),    18,   1, 0};
    tab[4]  = '{32'h0123_4ABC, mk_w1(1020, 0, 2, 0, 0), 2,    1, 6};
    tab[5]  = '{32'h0123_4ABC, mk_w1(1020, 0, 2, 0, 0), 5,    0, 0};
    tab[6]  = '{32'h003C_8100, mk_w1(3, 1, 0, 0, 0),    10,   0, 0};
    tab[7]  = '{32'h03FF_7FFF, mk_w1(100, 3, 3, 0, 0),  163,  1, 63};
    tab[8]  = '{32'h03FF_7FFF, mk_w1(100, 3, 3, 1, 0),  163,  1, 0};
    tab[9]  = '{32'h03FF_7FFF, mk_w1(100, 3, 3, 0, 0),  164,  0, 0};
    tab[10] = '{32'h0200_0001, mk_w1(1023, 2, 1, 0, 1), 1023, 1, 0};
    tab[11] = '{32'h0200_0001, mk_w1(1023, 2, 1, 0, 0), 30,   1, 31};
    tab[12] = '{32'h0200_0001, mk_w1(1023, 2, 1, 0, 0), 31,   0, 0};

    clear_mem();
    rst = 1'b1;
    line_start = 1'b0;
    line_idx = '0;
    spr_ready = 1'b0;
    ready_mode = 0;
    ready_fixed = 1;
    clear_obs();
    #2;
    check("reset_a", {busy_a, done_a, ovf_a, valid_a, en_a, raddr_a, pack_a}, 64'd0);
    check("reset_b", {busy_b, done_b, ovf_b, valid_b, en_b, raddr_b, pack_b}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single-sprite hit test vectors, sprite placed at entry 1
    for (int i = 0; i < 13; i++) begin
      clear_mem();
      mem[2] = tab[i].w0;
      mem[3] = tab[i].w1;
      run_scan(tab[i].line, 2000);
      check("tab_hits", 64'(got_a.size()), 64'(tab[i].exp_hit));
      if (tab[i].exp_hit == 1 && got_a.size() == 1)
        check("tab_row", 64'(got_a[0][18:13]), 64'(tab[i].exp_row));
      if (i == 0 && got_a.size() == 1)
        check("tab0_fields", 64'({got_a[0][48:42], got_a[0][41:30], got_a[0][29], got_a[0][28:19]}),
              64'({7'd1, 12'h100, 1'b1, 10'd60}));
      compare_scan("tab_scan", 0, 128, 64, tab[i].line);
    end

    // Empty table: 3 cycles per sprite, done_o one cycle after DONE
    clear_mem();
    run_scan(77, 2000);
    check("idle_scan_latency", 64'(done_cyc - first_en), 64'(3 * 128 + 1));
    check("idle_scan_records", 64'(got_a.size()), 64'd0);

    // Budget on the 8-sprite/4-record instance: six hits, overflow expected
    clear_mem();
    foreach (tab[i]) ;
    for (int k = 0; k < 8; k++)
      if (k == 0 || k == 2 || k == 3 || k == 5 || k == 6 || k == 7)
        mem[2*k+1] = mk_w1(50, 0, 1, 0, 0);
    run_scan(52, 2000);
    compare_scan("budget6", 1, 8, 4, 52);
    check("budget6_count", 64'(got_b.size()), 64'd4);
    if (got_b.size() == 4) check("budget6_last_idx", 64'(got_b[3][48:42]), 64'd5);
    check("budget6_ovf", 64'(ovf_done_b), 64'd1);
    for (int k = 0; k < 5; k++) step(0);
    check("budget6_ovf_held", 64'(ovf_b), 64'd1);

    // Fourth hit at the last scanned index: no overflow
    clear_mem();
    for (int k = 0; k < 9; k++)
      if (k == 1 || k == 3 || k == 5 || k == 7 || k == 8)
        mem[2*k+1] = mk_w1(50, 0, 1, 0, 0);
    run_scan(52, 2000);
    check("budget_restart_clears_ovf", 64'(ovf_b_post_start), 64'd0);
    compare_scan("budget_last", 1, 8, 4, 52);
    check("budget_last_ovf", 64'(ovf_done_b), 64'd0);
    if (got_b.size() == 4) check("budget_last_idx", 64'(got_b[3][48:42]), 64'd7);

    // Back-pressure stall, then restart coinciding with ready
    clear_mem();
    mem[2] = 32'h003C_8100;
    mem[3] = mk_w1(3, 1, 1, 0, 0);
    ready_fixed = 0;
    clear_obs();
    line_idx = 10'd10;
    step(1);
    n = 0;
    while (!valid_a && n < 50) begin step(0); n++; end
    check("stall_valid_seen", 64'(valid_a), 64'd1);
    hold = pack_a;
    stable_err = 0;
    rd_err = 0;
    for (int k = 0; k < 10; k++) begin
      step(0);
      if (!valid_a || pack_a !== hold) stable_err++;
      if (en_a) rd_err++;
    end
    check("stall_stable", 64'(stable_err), 64'd0);
    check("stall_no_read", 64'(rd_err), 64'd0);
    clear_obs();
    ready_fixed = 1;
    step(1);
    step(0);
    check("abort_valid_drop", 64'(valid_a), 64'd0);
    check("abort_restart_rd", {en_a, raddr_a}, {1'b1, 8'h00});
    n = 0;
    while (done_cnt_a == 0 && n < 2000) begin step(0); n++; end
    check("abort_records", 64'(got_a.size()), 64'd1);
    check("abort_done_count", 64'(done_cnt_a), 64'd1);

    // Asynchronous reset in the middle of a scan
    run_scan(10, 2000);
    line_idx = 10'd10;
    step(1);
    for (int k = 0; k < 15; k++) step(0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_a", {busy_a, done_a, ovf_a, valid_a, en_a, raddr_a, pack_a}, 64'd0);
    check("async_reset_b", {busy_b, done_b, ovf_b, valid_b, en_b, raddr_b, pack_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(0);
    check("async_reset_stays_idle", {busy_a, en_a, busy_b}, 64'd0);

    // Randomised tables with random back-pressure on both instances
    ready_mode = 1;
    for (int t = 0; t < 10; t++) begin
      line = int'($urandom_range(0, 1023));
      n = int'($urandom_range(20, 150));
      for (int e = 0; e < 128; e++) begin
        mem[2*e]   = $urandom;
        mem[2*e+1] = $urandom;
        mem[2*e+1][9:0] = 10'(line - int'($urandom_range(0, n)));
      end
      run_scan(line, 5000);
      compare_scan("rand_a", 0, 128, 64, line);
      compare_scan("rand_b", 1, 8, 4, line);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sprite_line_scanner.md
Name: sprite_line_scanner

Overview:
- Downstream consumer of the sprite attribute RAM (256 x 32, two words per sprite, 128 sprites, 1-cycle registered read).
- On each line-start request it walks all sprite entries in index order and emits one record per sprite that intersects the requested line, through a valid/ready handshake, to the sprite line renderer.
- Enforces a per-line sprite budget and reports overflow.

Parameters:
- NUM_SPRITES, 128, sprite entries scanned (2..128); entry n occupies words 2n and 2n+1.
- MAX_PER_LINE, 64, maximum records emitted per line (1..128).

Ports:
- clk_i  in  1  single clock; also drives the RAM read clock.
- rst_i  in  1  asynchronous, active-high reset.
- line_start_i  in  1  one-cycle pulse: start (or restart) a scan.
- line_idx_i  in  10  line to scan; sampled on line_start_i.
- ram_rd_en_o  out  1  RAM read enable.
- ram_rd_addr_o  out  8  RAM word address.
- ram_rd_data_i  in  32  RAM data, valid the cycle after ram_rd_en_o.
- spr_valid_o  out  1  record valid.
- spr_ready_i  in  1  renderer accepts the record.
- spr_idx_o  out  7  sprite index.
- spr_addr_o  out  12  pixel data address (word0[11:0]).
- spr_mode_o  out  1  colour mode (word0[15]).
- spr_x_o  out  10  x position (word0[25:16]).
- spr_row_o  out  6  row within the sprite, flip applied.
- spr_hflip_o  out  1  word1[16].
- spr_z_o  out  2  word1[19:18].
- spr_coll_o  out  4  collision mask (word1[23:20]).
- spr_pal_o  out  4  palette offset (word1[27:24]).
- spr_width_o  out  2  width code (word1[29:28]).
- busy_o  out  1  scan in progress.
- done_o  out  1  one-cycle pulse at scan end.
- overflow_o  out  1  budget was hit on the last scan; held until the next line_start_i.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States and transitions:
  - IDLE: line_start_i latches line_idx_i, clears idx/hit count/overflow_o, then goes to RD_EVEN.
  - RD_EVEN: ram_rd_en_o=1, addr={idx,0}; next state RD_ODD.
  - RD_ODD: ram_rd_en_o=1, addr={idx,1}; capture ram_rd_data_i as word0; next state EVAL.
  - EVAL: ram_rd_data_i is word1; evaluate the sprite. On a hit, register the record and go to EMIT. Otherwise go to NEXT.
  - EMIT: spr_valid_o=1; fields held stable while valid and not ready. On spr_ready_i, drop valid, increment hit count, then go to NEXT.
  - NEXT: behaves as a combinational decision folded into the preceding cycle, not a separate state.
    - If hit count == MAX_PER_LINE: set overflow_o; go to DONE.
    - Else if idx == NUM_SPRITES-1: go to DONE.
    - Else idx+1, go to RD_EVEN.
  - DONE: done_o=1 for one cycle; busy_o=0 from the following cycle; go to IDLE.
- busy_o = 1 in every state except IDLE.
- ram_rd_en_o and ram_rd_addr_o are registered, so they are asserted in the cycle after line_start_i.
- Minimum cost: 3 cycles per non-hitting sprite.
- Hit test:
  - Hit requires z != 0 and row < height.
  - Row = (line - word1[9:0]) mod 1024, 10-bit wrap-around subtraction. Sprites straddling line 0 must wrap correctly.
  - height = 8 << word1[31:30], giving 8/16/32/64.
- spr_row_o:
  - Equals row[5:0].
  - If vflip (word1[17]), spr_row_o = height-1-row.
- Budget: overflow_o sets only when a further sprite remains to be scanned after the budget is reached. Exactly MAX_PER_LINE hits on the final sprite does not set overflow_o.
- line_start_i in any non-IDLE state:
  - Aborts the scan and drops spr_valid_o in the next cycle; no done_o for the aborted scan.
  - Restarts from idx 0 with the new line.
  - If spr_ready_i coincides with line_start_i, the restart wins and the record is not counted.
- Async reset mid-scan: immediate return to IDLE with all outputs 0.
- spr_ready_i outside EMIT is ignored.

Test Plan:
- Sprite 1: word2=0x003C_8100, word1 y=3, height code 1, z=1; line_start line 10, spr_ready_i=1 -> one record with idx=1, addr=0x100, x=60, mode=1, row=7. done_o fires after all 128 entries; overflow_o=0.
- Same sprite with vflip=1 -> spr_row_o=8. With line 19 (row 16 == height) -> no record.
- Wrap: y=1020, height code 0, line 2 -> record with row=6. Line 5 (row 9) -> no record.
- z=0 on an otherwise matching sprite -> no record. All sprites z=0 -> done_o exactly 3*128+1 cycles after ram_rd_en_o first rises.
- MAX_PER_LINE=4, six matching sprites -> exactly 4 records (lowest indices), then done_o with overflow_o=1. Five matches with the 4th at the last index -> overflow_o=0.
- Hold spr_ready_i=0 for 10 cycles -> valid and fields stable, no RAM reads. Then pulse line_start_i with ready=1 in the same cycle -> valid drops, scan restarts at addr 0, no done_o for the aborted scan.
